// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, oversampling constants
// and the 2-of-3 vote used by the optional majority sampler.
package uart_pkg;

  localparam int OVERSAMPLE      = 8;
  localparam int SAMPLE_POINT    = 4;
  localparam int DEFAULT_CLK_DIV = 44;

  typedef logic [2:0] uart_state_t;

  localparam logic [2:0] ST_ARM   = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample prescaler: counts 0..CLK_DIV-1 and flags a tick on the last count.
// A synchronous clear realigns the sampling phase to a detected edge.
module uart_baud_tick #(
  parameter int CLK_DIV = 44
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 8x oversampled, valid/ready byte output with framing and
// overrun pulses. Define UART_RX_MAJORITY_EN for 2-of-3 sampling at sub 2/3/4.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int DATA_BITS = 8
) (
  input  logic                 user_clock,
  input  logic                 rst,
  input  logic                 usb_rs232_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output uart_state_t          dbg_state
);
  // Handshake: rx_valid rises with rx_data and both hold until a clock edge
  // sees rx_valid && rx_ready; a completion in that same cycle reloads rx_data.
  localparam int BCW = $clog2(DATA_BITS + 1);

  logic                 rxd_meta_q, rxd_sync_q;
  uart_state_t          state_q, state_d;
  logic [2:0]           sub_q, sub_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 tick, baud_clr, decide, wrap, complete, sample;

  uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud (
    .clk   (user_clock),
    .rst_n (rst),
    .clr   (baud_clr),
    .tick  (tick)
  );

  assign decide = tick && (sub_q == 3'(SAMPLE_POINT));
  assign wrap   = tick && (sub_q == 3'(OVERSAMPLE - 1));

`ifdef UART_RX_MAJORITY_EN
  logic samp_a_q, samp_a_d, samp_b_q, samp_b_d;

  always_comb begin
    samp_a_d = samp_a_q;
    samp_b_d = samp_b_q;
    if (tick && sub_q == 3'(SAMPLE_POINT - 2)) samp_a_d = rxd_sync_q;
    if (tick && sub_q == 3'(SAMPLE_POINT - 1)) samp_b_d = rxd_sync_q;
  end

  always_ff @(posedge user_clock or negedge rst) begin
    if (!rst) begin
      samp_a_q <= 1'b1;
      samp_b_q <= 1'b1;
    end else begin
      samp_a_q <= samp_a_d;
      samp_b_q <= samp_b_d;
    end
  end

  assign sample = majority3(samp_a_q, samp_b_q, rxd_sync_q);
`else
  assign sample = rxd_sync_q;
`endif

  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    baud_clr    = 1'b0;
    complete    = 1'b0;

    if (tick && (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP))
      sub_d = sub_q + 3'd1;

    case (state_q)
      ST_ARM: if (rxd_sync_q) state_d = ST_IDLE;
      ST_IDLE: begin
        if (!rxd_sync_q) begin
          baud_clr = 1'b1;
          sub_d    = '0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (decide && sample) state_d = ST_IDLE;
        else if (wrap) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (decide) begin
          shift_d   = (shift_q >> 1) | (DATA_BITS'(sample) << (DATA_BITS - 1));
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (wrap && bit_cnt_q == BCW'(DATA_BITS)) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (decide) begin
          if (sample) begin
            complete = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            // Low stop bit may be a break: rearm until the line returns high.
            frame_err_d = 1'b1;
            state_d     = ST_ARM;
          end
        end
      end
      default: state_d = ST_ARM;
    endcase

    if (complete) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge user_clock or negedge rst) begin
    if (!rst) begin
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      state_q     <= ST_ARM;
      sub_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rxd_meta_q  <= usb_rs232_rxd;
      rxd_sync_q  <= rxd_meta_q;
      state_q     <= state_d;
      sub_q       <= sub_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = frame_err_q;
  assign rx_overrun   = overrun_q;
  assign dbg_state    = state_q;

endmodule
